md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   Sits in EX beside the single-cycle ALU and takes the same A/B operands
//   from the register-file/forwarding muxes. Results leave through HI/LO to the
//   writeback mux (MFHI/MFLO). busy stalls the issue stage.
// PARAMETERS
//   MUL_LAT   5   cycles from accepted MULT/MULTU to HI/LO update (>=1)
// PORTS
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-high reset
//   start    in   1   request valid; sampled only while busy==0
//   MDOp     in   3   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   A        in   32  rs operand (dividend / multiplicand / MTHI-MTLO source)
//   B        in   32  rt operand (divisor / multiplier)
//   busy     out  1   operation in flight; new start ignored
//   done     out  1   one-cycle pulse in the cycle HI/LO take a mult/div result
//   HI       out  32  HI register (product[63:32] / remainder)
//   LO       out  32  LO register (product[31:0] / quotient)
// BEHAVIOUR
//   Reset (rst=1 at clk edge, any state): state=IDLE, HI=LO=0, busy=0, done=0;
//     aborts any in-flight op, no partial result written.
//   States: IDLE, MUL, DIV, DFIX.
//   IDLE: start&&MDOp==MULT/MULTU -> latch A,B, counter=MUL_LAT-1, -> MUL, busy=1.
//     start&&MDOp==DIV/DIVU -> latch |A|,|B| (signed) or A,B (unsigned) plus
//     sign flags, counter=31, -> DIV, busy=1.
//     start&&MTHI -> HI<=A next edge; MTLO -> LO<=A; stay IDLE, busy stays 0,
//     done stays 0. NOP/7 or start=0: no change.
//   MUL: product is 64-bit: signed*signed for MULT, unsigned for MULTU.
//     counter decrements each cycle; at counter==0: {HI,LO}<=product,
//     done=1, busy=0, -> IDLE. Total busy = MUL_LAT cycles.
//   DIV: radix-2 restoring, one quotient bit per cycle, 32 iterations;
//     counter==0 -> DFIX. DFIX: apply signs (quotient negated if signs
//     differ, remainder takes dividend sign, truncation toward zero), write
//     LO=quotient, HI=remainder, done=1, busy=0, -> IDLE. Busy = 33 cycles.
//   HI/LO hold old values throughout MUL/DIV; they change only at done or MT*.
//   busy asserts the cycle after the accepting edge; start during busy is
//     dropped (issue stage must hold it). A start can be accepted in the
//     cycle done is high (busy already 0 that cycle).
//   Divide by zero (B==0, DIV or DIVU): LO=32'hFFFF_FFFF, HI=A (original,
//     signed value), same 33-cycle latency, done pulses normally.
//   Signed overflow 32'h8000_0000 / -1: LO=32'h8000_0000, HI=0.
//   A/B changes after acceptance have no effect (operands latched).
// TESTING
//   1 MULT A=-3, B=7, MUL_LAT=5 -> busy 5 cycles, done once; HI=FFFF_FFFF, LO=FFFF_FFEB.
//   2 MULTU A=B=FFFF_FFFF -> HI=FFFF_FFFE, LO=0000_0001 after MUL_LAT cycles.
//   3 DIV A=-7, B=2 -> 33 busy cycles; LO=FFFF_FFFD, HI=FFFF_FFFF; DIVU 7/2 -> LO=3, HI=1.
//   4 DIV A=8000_0000, B=FFFF_FFFF -> LO=8000_0000, HI=0; DIVU A=5, B=0 -> LO=FFFF_FFFF, HI=5.
//   5 MTHI A=1234 then MTLO A=5678 back-to-back -> HI=1234, LO=5678, busy/done stay 0;
//     start asserted mid-DIV -> ignored, HI/LO unchanged until DIV done.
//   6 rst at cycle 10 of DIV -> next cycle busy=0, done=0, HI=LO=0; fresh MULT then completes correctly.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// state | meaning: IDLE accept ops, MT* update | MUL multiply countdown | DIV one quotient bit/cycle | DFIX signs, write HI/LO
module md_unit #(
    parameter int MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DFIX} state_t;

    localparam int CW = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 5;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic          sgn_q, sgn_d;
    logic [31:0]   rem_q, rem_d, quo_q, quo_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          done_q, done_d;

    logic [63:0] ext_a, ext_b, product;
    logic [31:0] div_mag;
    logic [32:0] trial, diff;
    logic        q_neg, r_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Sign-extend for MULT so the low 64 bits of one unsigned multiply serve both forms.
    assign ext_a   = {{32{sgn_q & a_q[31]}}, a_q};
    assign ext_b   = {{32{sgn_q & b_q[31]}}, b_q};
    assign product = ext_a * ext_b;

    // quo_q shifts the dividend magnitude out of its top while quotient bits enter below.
    assign div_mag = (sgn_q && b_q[31]) ? -b_q : b_q;
    assign trial   = {rem_q, quo_q[31]};
    assign diff    = trial - {1'b0, div_mag};
    assign q_neg   = sgn_q & (a_q[31] ^ b_q[31]);
    assign r_neg   = sgn_q & a_q[31];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (MDOp)
                        3'd1, 3'd2: begin
                            a_d     = A;
                            b_d     = B;
                            sgn_d   = (MDOp == 3'd1);
                            cnt_d   = CW'(MUL_LAT - 1);
                            state_d = S_MUL;
                        end
                        3'd3, 3'd4: begin
                            a_d     = A;
                            b_d     = B;
                            sgn_d   = (MDOp == 3'd3);
                            rem_d   = '0;
                            quo_d   = (MDOp == 3'd3 && A[31]) ? -A : A;
                            cnt_d   = CW'(31);
                            state_d = S_DIV;
                        end
                        3'd5:    hi_d = A;
                        3'd6:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                rem_d = diff[32] ? trial[31:0] : diff[31:0];
                quo_d = {quo_q[30:0], ~diff[32]};
                if (cnt_q == '0) state_d = S_DFIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DFIX: begin
                if (b_q == '0) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = a_q;
                end else begin
                    lo_d = q_neg ? -quo_q : quo_q;
                    hi_d = r_neg ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        HI   = hi_q;
        LO   = lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table of mult/div results plus multi-cycle corner sequences.
module tb_md_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] HI, LO;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    md_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .HI   (HI),
        .LO   (LO)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int lat,
                          input string tag);
        int n;
        @(negedge clk);
        start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0; A = ~a; B = ~b;
        chk({tag, "_busy_on"}, 32'(busy), 32'd1);
        chk({tag, "_hi_hold"}, HI, m_hi);
        chk({tag, "_lo_hold"}, LO, m_lo);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hi"}, HI, hi);
        chk({tag, "_lo"}, LO, lo);
        m_hi = hi;
        m_lo = lo;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0]  = '{3'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[3]  = '{3'd4, 32'd7,         32'd2,         32'd1,         32'd3,         DIV_LAT};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT};
        vecs[5]  = '{3'd4, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_LAT};
        vecs[6]  = '{3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT};
        vecs[7]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         MUL_LAT};
        vecs[8]  = '{3'd2, 32'h8000_0000, 32'd2,         32'd1,         32'd0,         MUL_LAT};
        vecs[9]  = '{3'd1, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'd0,         MUL_LAT};
        vecs[10] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT};
        vecs[11] = '{3'd4, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF, DIV_LAT};
        vecs[12] = '{3'd3, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'd0,         DIV_LAT};
        vecs[13] = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT};
        vecs[14] = '{3'd3, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14,        DIV_LAT};
        vecs[15] = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         MUL_LAT};

        rst = 1'b1; start = 1'b0; MDOp = 3'd0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat,
                   $sformatf("v%0d", i));

        // MTHI then MTLO back-to-back: single-cycle, never busy, no done.
        @(negedge clk);
        start = 1'b1; MDOp = 3'd5; A = 32'h1234;
        @(negedge clk);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_done", 32'(done), 32'd0);
        chk("mthi_hi", HI, 32'h1234);
        MDOp = 3'd6; A = 32'h5678;
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0;
        chk("mtlo_hi", HI, 32'h1234);
        chk("mtlo_lo", LO, 32'h5678);
        chk("mtlo_busy", 32'(busy), 32'd0);
        chk("mtlo_done", 32'(done), 32'd0);
        m_hi = 32'h1234; m_lo = 32'h5678;

        // Start presented mid-DIV is dropped; start during the done cycle is taken.
        @(negedge clk);
        start = 1'b1; MDOp = 3'd4; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0;
        repeat (8) @(negedge clk);
        start = 1'b1; MDOp = 3'd5; A = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("middiv_hi_%0d", i), HI, m_hi);
            chk($sformatf("middiv_lo_%0d", i), LO, m_lo);
            chk($sformatf("middiv_busy_%0d", i), 32'(busy), 32'd1);
        end
        start = 1'b0; MDOp = 3'd0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("middiv_done", 32'(done), 32'd1);
        chk("middiv_res_hi", HI, 32'd2);
        chk("middiv_res_lo", LO, 32'd14);
        start = 1'b1; MDOp = 3'd5; A = 32'hABCD;
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0;
        chk("done_cycle_mthi_hi", HI, 32'hABCD);
        chk("done_cycle_mthi_lo", LO, 32'd14);
        chk("done_cycle_busy", 32'(busy), 32'd0);
        m_hi = 32'hABCD; m_lo = 32'd14;

        // Reset in cycle 10 of a DIV aborts it with HI/LO cleared.
        @(negedge clk);
        start = 1'b1; MDOp = 3'd3; A = 32'hFFFF_FFF9; B = 32'd2;
        @(negedge clk);
        start = 1'b0; MDOp = 3'd0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        run_op(3'd1, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, MUL_LAT, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
